trj_seq_trig: RTL and testbench
===============================

// Module: trj_seq_trig
// PURPOSE
//  Parametrised, sequence-based trigger for the RISC-V core trojan benchmark suite. Watches a
//  register-value stream and fires only after NUM_STAGES masked patterns appear in order, each
//  within MAX_GAP cycles of the previous one. Generalises the single-word all-ones/all-zeros trigger
//  to arbitrary width, patterns, don't-care masks, multi-stage sequencing, timeout and pulse/sticky mode.
//  Sits beside the monitored register-file write port; drives the payload enable.
// PARAMETERS
//  DATA_W      64                      width of monitored word
//  NUM_STAGES  4                       sequence length, 1..16
//  PATTERNS    '1 (NUM_STAGES*DATA_W)  stage k pattern at [k*DATA_W +: DATA_W]
//  MASKS       '1 (NUM_STAGES*DATA_W)  stage k care-mask; 1 = bit compared
//  MAX_GAP     1024                    max cycles from one stage hit to the next; 0 = no timeout
//  STICKY      1                       1: trigger holds until clr/rst; 0: one-cycle pulse
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      synchronous reset, active-high
//  en           in   1                      arm; 0 forces IDLE
//  clr          in   1                      drop trigger, return to stage 0
//  data_valid   in   1                      data qualifies this cycle
//  data         in   DATA_W                 monitored word
//  trj_trigger  out  1                      registered trigger to payload
//  stage        out  $clog2(NUM_STAGES+1)   stages matched so far (debug)
// BEHAVIOUR
//  - One clock, reset synchronous active-high. Reset: trj_trigger=0, stage=0, gap counter=0, state IDLE.
//  - hit_k = data_valid & (((data ^ PATTERN_k) & MASK_k) == 0). Mask all-zero -> any valid word hits.
//  - States: IDLE, SEEK (stage index s in 0..NUM_STAGES-1), FIRED.
//  - IDLE: en=1 -> SEEK, s=0 next cycle. en=0 in any state -> IDLE, stage=0, trj_trigger=0 next cycle.
//  - SEEK s: hit_s -> s+1, gap=0; if s==NUM_STAGES-1 -> FIRED.
//    data_valid & !hit_s -> restart: s=1 if hit_0 (same word re-seeds), else s=0.
//    No data_valid: gap increments (saturating) when s>0; gap reaching MAX_GAP-1 with no hit -> s=0.
//    Hit on the cycle gap reaches MAX_GAP-1 counts (hit wins over timeout).
//  - FIRED: trj_trigger=1 registered, i.e. asserted the cycle after the final hit (latency 1).
//    STICKY=1: stay FIRED, ignore data, until clr or en=0 or rst.
//    STICKY=0: pulse one cycle, then SEEK s=0 automatically.
//  - clr has priority over hits, below rst and en=0: next cycle trj_trigger=0, SEEK s=0.
//  - NUM_STAGES=1: behaves as single-word detector, latency 1 (compatibility mode).
//  - stage output = s in SEEK, NUM_STAGES in FIRED, 0 in IDLE; registered.
//  - Gap counter width $clog2(MAX_GAP+1); absent/unused when MAX_GAP=0.
//  - No X propagation: data ignored when data_valid=0.
//  - All registers and comparison logic kept (dont_touch on module and ports) so synthesis
//    cannot collapse the trigger.
// STRUCTURE
//  - Shared package trj_pkg: state enum trj_state_e {IDLE,SEEK,FIRED}; helper function
//    trj_match(data,pat,mask); width constant TRJ_STAGE_W(n)=$clog2(n+1).
//  - Sub-module trj_masked_cmp (one per stage, generate loop): DATA_W-wide masked equality, pure
//    combinational, reduction-tree form.
//  - Top: stage mux, FSM, gap counter, output register.
// TESTING
//  - Defaults, PATTERNS all '1: en=1, four consecutive valid 64'hFFFF_FFFF_FFFF_FFFF -> trj_trigger=1
//    one cycle after 4th word, stage=4, held 100 cycles; clr -> 0 next cycle, stage=0.
//  - Stages A,B,C,D; send A,B,X,C,D -> no trigger, stage 0 after X; then A,B,C,D -> fires.
//  - Restart re-seed: A,B,A,B,C,D -> fires (3rd word A re-seeds stage 1).
//  - MAX_GAP=8: A, 7 idle cycles, B -> advances; A, 8 idle cycles, B -> stage back to 0, no fire.
//  - STICKY=0: full sequence -> single-cycle pulse, stage returns 0; repeat sequence -> second pulse.
//  - rst / en=0 mid-sequence (after A,B) -> stage=0, trigger=0 next cycle; mask bit[0]=0 with
//    data differing only in bit 0 still hits.

Source files
------------

// File: rtl/trj_pkg.sv
// Shared types and helpers for the sequence trigger: FSM state encoding,
// stage-count width and a scalar masked-match helper.
package trj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    FIRED = 2'd2
  } trj_state_e;

  localparam int TRJ_MAX_W = 256;

  // Width needed to report 0..n matched stages.
  function automatic int TRJ_STAGE_W(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic trj_match(input logic [TRJ_MAX_W-1:0] data,
                                     input logic [TRJ_MAX_W-1:0] pat,
                                     input logic [TRJ_MAX_W-1:0] mask);
    return (((data ^ pat) & mask) == '0);
  endfunction

endpackage

// File: rtl/trj_masked_cmp.sv
// Masked equality of one word against one stage pattern; a cleared mask bit
// is a don't-care, so an all-zero mask always matches.
module trj_masked_cmp #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] pattern_i,
  input  logic [DATA_W-1:0] mask_i,
  output logic              match_o
);

  logic [DATA_W-1:0] diff;

  assign diff    = (data_i ^ pattern_i) & mask_i;
  assign match_o = ~|diff;

endmodule

// File: rtl/trj_seq_trig.sv
// Sequence trigger: fires after NUM_STAGES masked patterns arrive in order,
// each within MAX_GAP cycles of the previous hit; sticky or one-cycle pulse.
(* dont_touch = "true" *)
module trj_seq_trig
  import trj_pkg::*;
#(
  parameter int                           DATA_W     = 64,
  parameter int                           NUM_STAGES = 4,
  parameter logic [NUM_STAGES*DATA_W-1:0] PATTERNS   = '1,
  parameter logic [NUM_STAGES*DATA_W-1:0] MASKS      = '1,
  parameter int                           MAX_GAP    = 1024,
  parameter bit                           STICKY     = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                clr,
  input  logic                                data_valid,
  input  logic [DATA_W-1:0]                   data,
  output logic                                trj_trigger,
  output logic [TRJ_STAGE_W(NUM_STAGES)-1:0]  stage
);

  localparam int            SW   = TRJ_STAGE_W(NUM_STAGES);
  localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

  trj_state_e            state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NUM_STAGES-1:0] match_vec;
  logic [NUM_STAGES-1:0] hit_vec;
  logic                  hit_sel;
  logic                  timeout;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_cmp
    trj_masked_cmp #(.DATA_W(DATA_W)) u_cmp (
      .data_i    (data),
      .pattern_i (PATTERNS[k*DATA_W +: DATA_W]),
      .mask_i    (MASKS[k*DATA_W +: DATA_W]),
      .match_o   (match_vec[k])
    );
  end

  // Qualifying with data_valid keeps unqualified (possibly X) data out of the FSM.
  assign hit_vec = match_vec & {NUM_STAGES{data_valid}};

  always_comb begin
    hit_sel = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (s_q == SW'(k)) hit_sel = hit_vec[k];
    end
  end

  // Gap counter runs only on idle cycles while partway through a sequence.
  if (MAX_GAP > 0) begin : g_gap
    localparam int GW = $clog2(MAX_GAP + 1);
    logic [GW-1:0] gap_q, gap_d;
    logic          gap_run;

    assign gap_run = en && !clr && (state_q == SEEK) && !data_valid && (s_q != '0);
    assign timeout = gap_run && (gap_q == GW'(MAX_GAP - 1));

    always_comb begin
      gap_d = '0;
      if (gap_run && !timeout) gap_d = gap_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) gap_q <= '0;
      else     gap_q <= gap_d;
    end
  end else begin : g_no_gap
    assign timeout = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    if (!en) begin
      state_d = IDLE;
      s_d     = '0;
    end else if (clr) begin
      state_d = SEEK;
      s_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SEEK;
          s_d     = '0;
        end
        SEEK: begin
          if (hit_sel) begin
            if (s_q == LAST) begin
              state_d = FIRED;
              s_d     = '0;
            end else begin
              s_d = s_q + 1'b1;
            end
          end else if (data_valid) begin
            // A broken sequence may itself be the start of a new one.
            s_d = hit_vec[0] ? SW'(1) : '0;
          end else if (timeout) begin
            s_d = '0;
          end
        end
        FIRED: begin
          if (!STICKY) begin
            state_d = SEEK;
            s_d     = '0;
          end
        end
        default: begin
          state_d = IDLE;
          s_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    trj_trigger = (state_q == FIRED);
    unique case (state_q)
      SEEK:    stage = s_q;
      FIRED:   stage = SW'(NUM_STAGES);
      default: stage = '0;
    endcase
  end

endmodule

// File: tb/tb_trj_seq_trig.sv
// Bench for trj_seq_trig: four differently configured instances share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_trj_seq_trig;

  localparam logic [63:0]  ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0]  PA      = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0]  PB      = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0]  PC      = 64'h5A5A_5A5A_0F0F_0F0F;
  localparam logic [63:0]  PD      = 64'hA5A5_A5A5_F0F0_F0F0;
  localparam logic [63:0]  PX      = 64'h1111_2222_3333_4444;
  localparam logic [63:0]  HI_FLIP = 64'hFFFF_0000_0000_0000;
  localparam logic [255:0] SEQ_PAT = {PD, PC, PB, PA};
  localparam logic [255:0] SEQ_MSK = {ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, ONES};
  localparam logic [63:0]  ONE_MSK = 64'h0000_0000_FFFF_FFFF;

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst, en, clr, data_valid;
  logic [63:0] data;
  always #5 clk = ~clk;

  logic       trig0, trig1, trig2, trig3;
  logic [2:0] st0, st1, st2;
  logic [0:0] st3;

  trj_seq_trig u_def (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .data_valid(data_valid), .data(data),
    .trj_trigger(trig0), .stage(st0));

  trj_seq_trig #(.PATTERNS(SEQ_PAT), .MASKS(SEQ_MSK), .MAX_GAP(8), .STICKY(1'b1)) u_seq (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .data_valid(data_valid), .data(data),
    .trj_trigger(trig1), .stage(st1));

  trj_seq_trig #(.PATTERNS(SEQ_PAT), .MAX_GAP(0), .STICKY(1'b0)) u_pulse (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .data_valid(data_valid), .data(data),
    .trj_trigger(trig2), .stage(st2));

  trj_seq_trig #(.NUM_STAGES(1), .PATTERNS(PA), .MASKS(ONE_MSK), .MAX_GAP(4), .STICKY(1'b0)) u_one (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .data_valid(data_valid), .data(data),
    .trj_trigger(trig3), .stage(st3));

  // model configuration and state
  int          cfg_n[4];
  int          cfg_gap[4];
  bit          cfg_sticky[4];
  logic [63:0] cfg_pat[4][4];
  logic [63:0] cfg_msk[4][4];
  bit          m_armed[4];
  bit          m_fired[4];
  int          m_cnt[4];
  int          m_idle[4];

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];

  function automatic bit mm(int i, int k, logic [63:0] d);
    return ((d ^ cfg_pat[i][k]) & cfg_msk[i][k]) == 64'd0;
  endfunction

  function automatic int exp_stage(int i);
    if (!m_armed[i]) return 0;
    if (m_fired[i])  return cfg_n[i];
    return m_cnt[i];
  endfunction

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      if (rst || !en) begin
        m_armed[i] = 0; m_fired[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
      end else if (clr) begin
        m_armed[i] = 1; m_fired[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
      end else if (!m_armed[i]) begin
        m_armed[i] = 1; m_cnt[i] = 0; m_idle[i] = 0;
      end else if (m_fired[i]) begin
        if (!cfg_sticky[i]) begin m_fired[i] = 0; m_cnt[i] = 0; end
      end else if (data_valid && mm(i, m_cnt[i], data)) begin
        m_cnt[i]++; m_idle[i] = 0;
        if (m_cnt[i] == cfg_n[i]) begin m_fired[i] = 1; m_cnt[i] = 0; end
      end else if (data_valid) begin
        m_cnt[i] = mm(i, 0, data) ? 1 : 0; m_idle[i] = 0;
      end else if (m_cnt[i] > 0 && cfg_gap[i] > 0) begin
        m_idle[i]++;
        if (m_idle[i] >= cfg_gap[i]) begin m_cnt[i] = 0; m_idle[i] = 0; end
      end
      exp_q.push_back({2'(i), 1'b0, m_fired[i], 4'(exp_stage(i))});
    end
  endtask

  function automatic int got_trig(int i);
    case (i)
      0: return int'(trig0);
      1: return int'(trig1);
      2: return int'(trig2);
      default: return int'(trig3);
    endcase
  endfunction

  function automatic int got_stage(int i);
    case (i)
      0: return int'(st0);
      1: return int'(st1);
      2: return int'(st2);
      default: return int'(st3);
    endcase
  endfunction

  // scoreboard: every driven cycle is checked against the model on the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      automatic logic [7:0] e = exp_q.pop_front();
      automatic int i = int'(e[7:6]);
      tests++;
      if (got_trig(i) != int'(e[4]) || got_stage(i) != int'(e[3:0])) begin
        fails++;
        $display("FAIL cmp_u%0d: trig=%0d stage=%0d, expected trig=%0d stage=%0d",
                 i, got_trig(i), got_stage(i), e[4], e[3:0]);
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic drv(bit r, bit e, bit c, bit v, logic [63:0] d);
    rst = r; en = e; clr = c; data_valid = v; data = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(logic [63:0] d);
    drv(1'b0, 1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) drv(1'b0, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
  endtask

  task automatic do_clr();
    drv(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
  endtask

  initial begin
    cfg_n      = '{4, 4, 4, 1};
    cfg_gap    = '{1024, 8, 0, 4};
    cfg_sticky = '{1, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      cfg_pat[0][k] = ONES;                    cfg_msk[0][k] = ONES;
      cfg_pat[1][k] = SEQ_PAT[k*64 +: 64];     cfg_msk[1][k] = SEQ_MSK[k*64 +: 64];
      cfg_pat[2][k] = SEQ_PAT[k*64 +: 64];     cfg_msk[2][k] = ONES;
      cfg_pat[3][k] = PA;                      cfg_msk[3][k] = ONE_MSK;
    end
    for (int i = 0; i < 4; i++) begin
      m_armed[i] = 0; m_fired[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
    end

    drv(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    drv(1'b1, 1'b1, 1'b0, 1'b1, ONES);
    chk("reset_trig", int'(trig0), 0);
    chk("reset_stage", int'(st0), 0);

    drv(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    chk("arm_stage", int'(st0), 0);
    repeat (3) send(ONES);
    chk("ones3_stage", int'(st0), 3);
    chk("ones3_trig", int'(trig0), 0);
    send(ONES);
    chk("ones4_trig", int'(trig0), 1);
    chk("ones4_stage", int'(st0), 4);
    for (int j = 0; j < 100; j++) drv(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    chk("hold_trig", int'(trig0), 1);
    do_clr();
    chk("clr_trig", int'(trig0), 0);
    chk("clr_stage", int'(st0), 0);

    send(PA); send(PB);
    chk("ab_stage", int'(st1), 2);
    send(PX);
    chk("x_restart", int'(st1), 0);
    send(PC); send(PD);
    chk("abxcd_trig", int'(trig1), 0);
    send(PA); send(PB); send(PC); send(PD);
    chk("abcd_trig", int'(trig1), 1);
    chk("pulse1_trig", int'(trig2), 1);
    chk("pulse1_stage", int'(st2), 4);
    send(PX);
    chk("pulse_end_trig", int'(trig2), 0);
    chk("pulse_end_stage", int'(st2), 0);
    chk("sticky_hold", int'(trig1), 1);
    send(PA); send(PB); send(PC); send(PD);
    chk("pulse2_trig", int'(trig2), 1);

    do_clr();
    send(PA); send(PB); send(PA); send(PB); send(PC); send(PD);
    chk("reseed_trig", int'(trig1), 1);

    do_clr();
    send(PA); idle(7); send(PB);
    chk("gap7_stage", int'(st1), 2);
    do_clr();
    send(PA); idle(8);
    chk("gap8_stage", int'(st1), 0);
    send(PB);
    chk("gap8_b_stage", int'(st1), 0);
    chk("gap8_trig", int'(trig1), 0);

    do_clr();
    send(PA); send(PB ^ 64'd1);
    chk("mask_bit0", int'(st1), 2);

    do_clr();
    send(PA); send(PB);
    drv(1'b0, 1'b0, 1'b0, 1'b1, PC);
    chk("en0_stage", int'(st1), 0);
    chk("en0_trig", int'(trig1), 0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    send(PA); send(PB);
    drv(1'b1, 1'b1, 1'b0, 1'b1, PC);
    chk("rst_mid_stage", int'(st1), 0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    send(PA ^ HI_FLIP);
    chk("single_trig", int'(trig3), 1);
    chk("single_stage", int'(st3), 1);

    // randomized phase; half of the valid words steer u_seq along its sequence
    for (int n = 0; n < 3000; n++) begin
      automatic bit          r = ($urandom_range(0, 199) == 0);
      automatic bit          e = ($urandom_range(0, 99) != 0);
      automatic bit          c = ($urandom_range(0, 99) == 0);
      automatic bit          v = ($urandom_range(0, 9) < 6);
      automatic logic [63:0] d;
      if ($urandom_range(0, 1) == 1) d = cfg_pat[1][m_cnt[1] % 4];
      else begin
        case ($urandom_range(0, 7))
          0: d = PA;
          1: d = PB;
          2: d = PC;
          3: d = PD;
          4: d = PB ^ 64'd1;
          5: d = ONES;
          6: d = PA ^ HI_FLIP;
          default: d = {$urandom, $urandom};
        endcase
      end
      drv(r, e, c, v, d);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
